// File: rtl/i2c_master_ctrl.sv
// i2c_master_ctrl: register-level I2C master (8-bit register address, 1 or 2 data bytes)
// driving SCL/SDA through open-drain enables.
module i2c_master_ctrl #(
  parameter int CLK_DIV = 125
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        rw,
  input  logic        len2,
  input  logic [6:0]  dev_addr,
  input  logic [7:0]  reg_addr,
  input  logic [15:0] wr_data,
  input  logic        sda_i,
  output logic        sda_oe,
  output logic        scl_oe,
  output logic        busy,
  output logic        done,
  output logic        ack_err,
  output logic [15:0] rd_data
);
  typedef enum logic [3:0] {
    S_IDLE, S_START, S_DEV_W, S_A_DEV, S_REG, S_A_REG, S_DATA_W, S_A_DAT,
    S_RSTART, S_DEV_R, S_A_DR, S_DATA_R, S_MACK, S_STOP
  } state_t;
  state_t state, ns;
  logic [15:0] tmr, wdat, rdat;
  logic [7:0] reg_r, tx_byte;
  logic [6:0] dev;
  logic [2:0] bitc;
  logic [1:0] q;
  logic rw_r, len2_r, second, tick, bit_end, last, tx_bit, tx_st, ack_st;
  always_comb begin
    busy = state != S_IDLE;
    tick = busy && tmr == 16'(CLK_DIV - 1);
    bit_end = tick && q == 2'd3;
    last = !len2_r || second;
    tx_st = state inside {S_DEV_W, S_REG, S_DATA_W, S_DEV_R};
    ack_st = state inside {S_A_DEV, S_A_REG, S_A_DAT, S_A_DR};
    tx_byte = state == S_DEV_W ? {dev, 1'b0} : state == S_DEV_R ? {dev, 1'b1} :
              state == S_REG ? reg_r : (len2_r && !second) ? wdat[15:8] : wdat[7:0];
    tx_bit = tx_byte[~bitc];
    scl_oe = state inside {S_IDLE, S_START} ? 1'b0 :
             state inside {S_RSTART, S_STOP} ? q == 2'd0 : !q[1];
    ns = state;
    if (state == S_IDLE) ns = start ? S_START : S_IDLE;
    else if (bit_end)
      case (state)
        S_START:  ns = S_DEV_W;
        S_DEV_W:  ns = bitc == 3'd7 ? S_A_DEV : state;
        S_REG:    ns = bitc == 3'd7 ? S_A_REG : state;
        S_DATA_W: ns = bitc == 3'd7 ? S_A_DAT : state;
        S_DEV_R:  ns = bitc == 3'd7 ? S_A_DR : state;
        S_DATA_R: ns = bitc == 3'd7 ? S_MACK : state;
        S_A_DEV:  ns = ack_err ? S_STOP : S_REG;
        S_A_REG:  ns = ack_err ? S_STOP : rw_r ? S_RSTART : S_DATA_W;
        S_A_DAT:  ns = (ack_err || last) ? S_STOP : S_DATA_W;
        S_RSTART: ns = S_DEV_R;
        S_A_DR:   ns = ack_err ? S_STOP : S_DATA_R;
        S_MACK:   ns = last ? S_STOP : S_DATA_R;
        default:  ns = S_IDLE;
      endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      tmr <= '0;
      q <= '0;
      bitc <= '0;
      sda_oe <= 1'b0;
      done <= 1'b0;
      ack_err <= 1'b0;
      rd_data <= '0;
      rdat <= '0;
      second <= 1'b0;
      rw_r <= 1'b0;
      len2_r <= 1'b0;
      dev <= '0;
      reg_r <= '0;
      wdat <= '0;
    end else begin
      state <= ns;
      done <= bit_end && state == S_STOP;
      tmr <= (!busy || tick) ? '0 : tmr + 16'd1;
      q <= busy ? q + 2'(tick) : 2'd0;
      if (!busy && start) begin
        rw_r <= rw;
        len2_r <= len2;
        dev <= dev_addr;
        reg_r <= reg_addr;
        wdat <= wr_data;
        ack_err <= 1'b0;
        rdat <= '0;
        second <= 1'b0;
        bitc <= '0;
      end
      if (bit_end && (tx_st || state == S_DATA_R)) bitc <= bitc + 3'd1;
      if (bit_end && (state == S_A_DAT || state == S_MACK) && ns != S_STOP) second <= 1'b1;
      if (tick && q == 2'd2 && ack_st && sda_i) ack_err <= 1'b1;
      if (tick && q == 2'd2 && state == S_DATA_R) rdat <= {rdat[14:0], sda_i};
      if (bit_end && state == S_STOP && rw_r && !ack_err) rd_data <= rdat;
      // SDA only moves on quarter ticks: data at q1 entry, START/Sr/STOP edges at q2 entry
      if (tick && q == 2'd0)
        sda_oe <= tx_st ? !tx_bit : state == S_MACK ? !last :
                  (ack_st || state == S_DATA_R) ? 1'b0 : sda_oe;
      if (tick && q == 2'd1 && state inside {S_START, S_RSTART, S_STOP}) sda_oe <= state != S_STOP;
      if (bit_end && ns == S_STOP) sda_oe <= 1'b1;
    end
  end
endmodule
